// File: rtl/uart_rx.sv
// 16x-oversampled UART receiver: 2-flop synchroniser, mid-bit majority vote,
// optional parity, framing/overrun detection and a one-entry valid/ready holding register.
module uart_rx #(
    parameter int CLK_HZ     = 50000000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY     = 0
) (
    input  logic       clk_50,
    input  logic       reset_n,
    input  logic       rx_line,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       parity_err,
    output logic       overrun,
    output logic       busy
);

    localparam int DIV_RAW = CLK_HZ / (BAUD * OVERSAMPLE);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int PW      = (DIV > 1) ? $clog2(DIV) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_WAIT_HIGH
    } state_t;

    state_t      state_q, state_d;
    logic        meta_q, rx_s_q;
    logic [PW-1:0] presc_q, presc_d;
    logic [3:0]  idx_q, idx_d;
    logic        s7_q, s7_d, s8_q, s8_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic        par_err_q, par_err_d;
    logic [7:0]  rx_data_q, rx_data_d;
    logic        rx_valid_q, rx_valid_d;
    logic        frame_err_q, frame_err_d;
    logic        parity_err_q, parity_err_d;
    logic        overrun_q, overrun_d;

    logic tick, maj, sample_now, bit_end, commit, stop_bit, transfer;

    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            meta_q <= 1'b1;
            rx_s_q <= 1'b1;
        end else begin
            meta_q <= rx_line;
            rx_s_q <= meta_q;
        end
    end

    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            presc_q      <= '0;
            idx_q        <= '0;
            s7_q         <= 1'b0;
            s8_q         <= 1'b0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            par_err_q    <= 1'b0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            presc_q      <= presc_d;
            idx_q        <= idx_d;
            s7_q         <= s7_d;
            s8_q         <= s8_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            par_err_q    <= par_err_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
            overrun_q    <= overrun_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        presc_d      = presc_q;
        idx_d        = idx_q;
        s7_d         = s7_q;
        s8_d         = s8_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        par_err_d    = par_err_q;
        rx_data_d    = rx_data_q;
        rx_valid_d   = rx_valid_q;
        frame_err_d  = frame_err_q;
        parity_err_d = parity_err_q;
        overrun_d    = 1'b0;
        commit       = 1'b0;
        stop_bit     = 1'b1;

        tick       = (presc_q == PW'(DIV - 1));
        maj        = (s7_q & s8_q) | (s7_q & rx_s_q) | (s8_q & rx_s_q);
        sample_now = tick && (idx_q == 4'd9);
        bit_end    = tick && (idx_q == 4'd15);
        transfer   = rx_valid_q && rx_ready;

        if (tick) begin
            presc_d = '0;
            idx_d   = idx_q + 4'd1;
        end else begin
            presc_d = presc_q + PW'(1);
        end
        if (tick && idx_q == 4'd7) s7_d = rx_s_q;
        if (tick && idx_q == 4'd8) s8_d = rx_s_q;

        case (state_q)
            S_IDLE: begin
                // Falling edge realigns the bit grid so tick 15 lands on bit boundaries
                if (!rx_s_q) begin
                    state_d   = S_START;
                    presc_d   = '0;
                    idx_d     = '0;
                    par_err_d = 1'b0;
                end
            end
            S_START: begin
                if (sample_now && maj) begin
                    state_d = S_IDLE;
                end else if (bit_end) begin
                    state_d   = S_DATA;
                    bit_cnt_d = '0;
                end
            end
            S_DATA: begin
                if (sample_now) shift_d = {maj, shift_q[7:1]};
                if (bit_end) begin
                    if (bit_cnt_q == 3'd7) begin
                        state_d = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            S_PARITY: begin
                if (sample_now) begin
                    par_err_d = (PARITY == 1) ? ~(^shift_q ^ maj) : (^shift_q ^ maj);
                end
                if (bit_end) state_d = S_STOP;
            end
            S_STOP: begin
                // Leave at the mid-bit decision so a back-to-back start edge is not missed
                if (sample_now) begin
                    commit   = 1'b1;
                    stop_bit = maj;
                    state_d  = maj ? S_IDLE : S_WAIT_HIGH;
                end
            end
            S_WAIT_HIGH: begin
                if (rx_s_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (commit && (!rx_valid_q || transfer)) begin
            rx_data_d    = shift_q;
            frame_err_d  = ~stop_bit;
            parity_err_d = (PARITY != 0) && par_err_q;
            rx_valid_d   = 1'b1;
        end else if (commit) begin
            overrun_d = 1'b1;
        end else if (transfer) begin
            rx_valid_d = 1'b0;
        end
    end

    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign frame_err  = frame_err_q;
    assign parity_err = parity_err_q;
    assign overrun    = overrun_q;
    assign busy       = (state_q != S_IDLE);

endmodule
